// File: rtl/conv_mac_acc_if.sv
// conv_mac_acc_if: beat/result bundle for the convolution MAC engine.
//   clear      abort current group and all in-flight beats
//   in_valid   beat present on in_data / in_weight / in_bias
//   in_data    TAPS packed signed samples, tap k at [k*DW +: DW]
//   in_weight  TAPS packed signed weights, same packing
//   in_bias    signed bias, taken from the last beat of a group
//   out_valid  one-cycle pulse when out_data holds a new pixel
//   out_data   signed saturated result, held between pulses
//   busy       group partially received or beats still in flight
// master = beat source, slave = engine.
interface conv_mac_acc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 25
);
  logic                         clear;
  logic                         in_valid;
  logic [TAPS*DATA_WIDTH-1:0]   in_data;
  logic [TAPS*DATA_WIDTH-1:0]   in_weight;
  logic [DATA_WIDTH-1:0]        in_bias;
  logic                         out_valid;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         busy;

  modport master (
    output clear, in_valid, in_data, in_weight, in_bias,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  clear, in_valid, in_data, in_weight, in_bias,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/conv_mac_acc.sv
// conv_mac_acc: convolution multiply-accumulate engine.
// Each beat carries a TAPS-wide window and weight set. Per-tap products are
// registered, reduced by a widening registered adder tree, accumulated over
// IN_CHANNELS beats, then biased, rescaled, optionally ReLU-clamped and
// saturated into one output pixel.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  conv_mac_acc_if slave modport (clear, beat inputs, result, busy)
// Pipeline: input reg -> products -> L tree levels -> accumulator -> output,
// giving L+3 cycles from the sampling edge of the last beat to out_valid.
module conv_mac_acc #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int TAPS        = 25,
  parameter int IN_CHANNELS = 1,
  parameter int RELU_EN     = 1
) (
  input logic           clk,
  input logic           rst,
  conv_mac_acc_if.slave bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int L     = $clog2(TAPS);
  localparam int PW    = 2 * DW;
  localparam int TW    = PW + L;
  localparam int ACC_W = 2 * DW + $clog2(TAPS * IN_CHANNELS) + 1;
  localparam int SW    = ACC_W + 1;
  localparam int CW    = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  // tag slot 0 = input register, 1 = products, 1+l = tree level l
  localparam int NP    = L + 2;

  localparam logic signed [SW-1:0] MAX_V = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Number of nodes present at tree level l (level 0 = raw products).
  function automatic int lvl_n(input int l);
    int n;
    n = TAPS;
    for (int i = 0; i < l; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic [CW-1:0]          ch_cnt_r;
  logic [CW-1:0]          cnt_base_s;
  logic [CW-1:0]          ch_cnt_next_s;
  logic                   beat_first_s;
  logic                   beat_last_s;
  logic [TAPS*DW-1:0]     din_r;
  logic [TAPS*DW-1:0]     wt_r;
  logic [NP-1:0]          v_r;
  logic [NP-1:0]          first_r;
  logic [NP-1:0]          last_r;
  logic signed [DW-1:0]   bias_r [NP];
  logic signed [TW-1:0]   tree_sum_s;
  logic signed [ACC_W-1:0] acc_r;
  logic                   a_valid_r;
  logic                   a_last_r;
  logic signed [DW-1:0]   a_bias_r;
  logic signed [SW-1:0]   sum_s;
  logic signed [SW-1:0]   shr_s;
  logic signed [SW-1:0]   clip_s;
  logic signed [DW-1:0]   res_s;
  logic                   out_valid_r;
  logic [DW-1:0]          out_data_r;

  // Channel tagging; clear restarts counting so a same-cycle beat is channel 0.
  always_comb begin
    cnt_base_s   = bus.clear ? '0 : ch_cnt_r;
    beat_first_s = (cnt_base_s == '0);
    beat_last_s  = (cnt_base_s == CW'(IN_CHANNELS - 1));
    if (bus.in_valid) begin
      if (beat_last_s) begin
        ch_cnt_next_s = '0;
      end else begin
        ch_cnt_next_s = cnt_base_s + CW'(1);
      end
    end else begin
      ch_cnt_next_s = cnt_base_s;
    end
  end

  // Channel counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt_r <= '0;
    end else begin
      ch_cnt_r <= ch_cnt_next_s;
    end
  end

  // Input register for window and weights (datapath, no reset needed).
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      din_r <= bus.in_data;
      wt_r  <= bus.in_weight;
    end
  end

  // Valid/first/last tag shift pipeline; clear kills every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r     <= '0;
      first_r <= '0;
      last_r  <= '0;
    end else begin
      v_r     <= {v_r[NP-2:0] & {(NP-1){~bus.clear}}, bus.in_valid};
      first_r <= {first_r[NP-2:0], beat_first_s};
      last_r  <= {last_r[NP-2:0], beat_last_s};
    end
  end

  // Bias travels alongside its beat.
  always_ff @(posedge clk) begin
    bias_r[0] <= bus.in_bias;
    for (int i = 1; i < NP; i++) begin
      bias_r[i] <= bias_r[i-1];
    end
  end

  // Product stage and widening adder tree, one register per level.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int N = lvl_n(l);
    localparam int W = PW + l;
    logic signed [W-1:0] node [N];

    if (l == 0) begin : g_mul
      for (genvar k = 0; k < N; k++) begin : g_tap
        logic signed [PW-1:0] a_s;
        logic signed [PW-1:0] b_s;
        // Sign-extend to full width so the low 2*DW product bits are exact.
        assign a_s = PW'($signed(din_r[k*DW +: DW]));
        assign b_s = PW'($signed(wt_r[k*DW +: DW]));
        // Full-precision signed product register.
        always_ff @(posedge clk) begin
          node[k] <= a_s * b_s;
        end
      end
    end else begin : g_add
      localparam int PN = lvl_n(l - 1);
      for (genvar k = 0; k < N; k++) begin : g_node
        if (2 * k + 1 < PN) begin : g_pair
          // Pairwise sum, each operand sign-extended by one bit.
          always_ff @(posedge clk) begin
            node[k] <= {g_lvl[l-1].node[2*k][W-2], g_lvl[l-1].node[2*k]}
                     + {g_lvl[l-1].node[2*k+1][W-2], g_lvl[l-1].node[2*k+1]};
          end
        end else begin : g_pass
          // Odd leftover passes through unchanged (sign-extended).
          always_ff @(posedge clk) begin
            node[k] <= {g_lvl[l-1].node[2*k][W-2], g_lvl[l-1].node[2*k]};
          end
        end
      end
    end
  end

  assign tree_sum_s = g_lvl[L].node[0];

  // Accumulator stage: first beat loads, later beats add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r     <= '0;
      a_valid_r <= 1'b0;
      a_last_r  <= 1'b0;
    end else begin
      a_valid_r <= v_r[NP-1] & ~bus.clear;
      a_last_r  <= last_r[NP-1];
      if (v_r[NP-1]) begin
        if (first_r[NP-1]) begin
          acc_r <= ACC_W'(tree_sum_s);
        end else begin
          acc_r <= acc_r + ACC_W'(tree_sum_s);
        end
      end
    end
  end

  // Bias travels with the accumulator slot it belongs to.
  always_ff @(posedge clk) begin
    a_bias_r <= bias_r[NP-1];
  end

  // Bias add, arithmetic rescale (floor), optional ReLU, saturation.
  always_comb begin
    sum_s = SW'(acc_r) + (SW'(a_bias_r) <<< FRAC_BITS);
    shr_s = sum_s >>> FRAC_BITS;
    if ((RELU_EN != 0) && shr_s[SW-1]) begin
      clip_s = '0;
    end else begin
      clip_s = shr_s;
    end
    if (clip_s > MAX_V) begin
      res_s = MAX_V[DW-1:0];
    end else if (clip_s < MIN_V) begin
      res_s = MIN_V[DW-1:0];
    end else begin
      res_s = clip_s[DW-1:0];
    end
  end

  // Output register: pulse on a last-tagged beat, data held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (bus.clear) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= a_valid_r & a_last_r;
      if (a_valid_r && a_last_r) begin
        out_data_r <= res_s;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = (ch_cnt_r != '0) | (|v_r) | a_valid_r;
endmodule
